// File: rtl/riscv_mc_pkg.sv
`default_nettype none
// ============================================================================
// riscv_mc_pkg -- shared types and encodings for the multicycle controller
// rev 1.0
// ============================================================================
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, LUI, ALUWB, BRANCH, JAL, TRAP
  } mc_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_PASS = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:        return IMM_S;
      OP_BRANCH:       return IMM_B;
      OP_JAL:          return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:         return IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_aludec.sv
`default_nettype none
// ============================================================================
// mc_aludec -- maps ALUOp and instruction function fields to ALUControl
// rev 1.0
// ============================================================================
module mc_aludec
  import riscv_mc_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:  alu_control = ALU_ADD;
      ALUOP_SUB:  alu_control = ALU_SUB;
      ALUOP_PASS: alu_control = ALU_PASS;
      default: begin
        case (funct3)
          // Only R-type has a sub; I-type reuses funct7b5 bits as immediate.
          3'b000:  alu_control = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// mc_controller -- multicycle RV32I control FSM with memory handshake
// rev 1.0
// ============================================================================
module mc_controller
  import riscv_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             n,
  input  logic             v,
  input  logic             C,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [3:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [1:0]       alu_op;
  logic             retire;
  logic             branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = !Zero;
      3'b100:  branch_taken = n ^ v;
      3'b101:  branch_taken = !(n ^ v);
      3'b110:  branch_taken = !C;
      3'b111:  branch_taken = C;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    retire    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = ALUWB;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      LUI: begin
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_PASS;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        PCWrite = branch_taken;
        retire  = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        // PC takes the DECODE target from ALUOut while the ALU forms the link.
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = ALUWB;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase

    if (!reset) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end

    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
  end

  mc_aludec u_aludec (
    .opb5        (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_op      (alu_op),
    .alu_control (ALUControl)
  );

  assign ImmSrc  = imm_src(op);
  assign illegal = (state_q == TRAP);
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// tb_mc_controller -- directed bench with an instruction-level reference model
// rev 1.0
// ============================================================================
module tb_mc_controller;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero, n, v, C, mem_ready;
  logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  mc_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .n(n), .v(v), .C(C), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal), .retired(retired)
  );

  int tests = 0;
  int fails = 0;

  // Instruction classes and the step within an instruction (0 = fetch, 1 = decode).
  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4,
                 K_JAL = 5, K_LUI = 6, K_AUIPC = 7, K_ILL = 8;

  function automatic int cls_of(input logic [6:0] o);
    case (o)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  // Last step index of each class with zero wait states (latency - 1).
  function automatic int last_step(input int k);
    case (k)
      K_LOAD:          return 4;
      K_BR, K_AUIPC:   return 2;
      K_ILL:           return 1000;
      default:         return 3;
    endcase
  endfunction

  function automatic bit mem_step(input int k, input int s);
    return (s == 0) || (s == 3 && (k == K_LOAD || k == K_STORE));
  endfunction

  function automatic logic [3:0] exp_alu(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (is_r && f7) ? 4'h1 : 4'h0;
      3'd1: return 4'h8;
      3'd2: return 4'h5;
      3'd3: return 4'h7;
      3'd4: return 4'h4;
      3'd5: return f7 ? 4'hA : 4'h9;
      3'd6: return 4'h3;
      default: return 4'h2;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic nn,
                                 input logic vv, input logic cc);
    case (f3)
      3'd0: return z;               // equal
      3'd1: return !z;              // not equal
      3'd4: return nn != vv;        // signed less than
      3'd5: return nn == vv;        // signed greater or equal
      3'd6: return !cc;             // unsigned less than (borrow)
      3'd7: return cc;              // unsigned greater or equal
      default: return 1'b0;
    endcase
  endfunction

  typedef struct packed { logic [19:0] v; logic [19:0] m; } exp_t;

  function automatic exp_t model_out(input int k, input int s, input logic rdy, input logic rst_n);
    exp_t r;
    logic mreq, mw, adr, irw, pcw, rw, ill;
    logic [1:0] rs, sa, sb;
    logic [3:0] ac;
    logic [2:0] imm;
    logic cadr, crs, csa, csb, cac, cimm;
    mreq = 0; mw = 0; adr = 0; irw = 0; pcw = 0; rw = 0; ill = 0;
    rs = 0; sa = 0; sb = 0; ac = 0;
    cadr = 0; crs = 0; csa = 0; csb = 0; cac = 0; cimm = 1;
    case (k)
      K_STORE:         imm = 3'b001;
      K_BR:            imm = 3'b010;
      K_JAL:           imm = 3'b011;
      K_LUI, K_AUIPC:  imm = 3'b100;
      K_LOAD, K_I:     imm = 3'b000;
      default: begin imm = 3'b000; cimm = 0; end
    endcase
    if (s == 0) begin
      mreq = 1; adr = 0; cadr = 1; sa = 0; sb = 2; ac = 0; rs = 2;
      csa = 1; csb = 1; cac = 1; crs = 1; irw = rdy; pcw = rdy;
    end else if (s == 1) begin
      sa = 1; sb = 1; ac = 0; csa = 1; csb = 1; cac = 1;
    end else begin
      case (k)
        K_LOAD, K_STORE: begin
          if (s == 2) begin sa = 2; sb = 1; ac = 0; csa = 1; csb = 1; cac = 1; end
          else if (s == 3) begin
            mreq = 1; adr = 1; cadr = 1;
            if (k == K_STORE) mw = 1; else crs = 1;
          end else begin rs = 1; crs = 1; rw = 1; end
        end
        K_R, K_I: begin
          if (s == 2) begin
            sa = 2; sb = (k == K_I) ? 2'd1 : 2'd0; ac = exp_alu(k == K_R, funct3, funct7b5);
            csa = 1; csb = 1; cac = 1;
          end else begin rs = 0; crs = 1; rw = 1; end
        end
        K_LUI: begin
          if (s == 2) begin sb = 1; ac = 4'h6; csb = 1; cac = 1; end
          else begin rs = 0; crs = 1; rw = 1; end
        end
        K_JAL: begin
          if (s == 2) begin
            pcw = 1; rs = 0; sa = 1; sb = 2; ac = 0; crs = 1; csa = 1; csb = 1; cac = 1;
          end else begin rs = 0; crs = 1; rw = 1; end
        end
        K_AUIPC: begin rs = 0; crs = 1; rw = 1; end
        K_BR: begin
          sa = 2; sb = 0; ac = 4'h1; rs = 0; csa = 1; csb = 1; cac = 1; crs = 1;
          pcw = taken(funct3, Zero, n, v, C);
        end
        default: ill = 1;
      endcase
    end
    if (!rst_n) begin
      mreq = 0; mw = 0; irw = 0; pcw = 0; rw = 0; ill = 0;
      cadr = 0; crs = 0; csa = 0; csb = 0; cac = 0;
    end
    r.v = {mreq, mw, adr, irw, pcw, rw, rs, sa, sb, imm, ac, ill};
    r.m = {2'b11, cadr, 3'b111, {2{crs}}, {2{csa}}, {2{csb}}, {3{cimm}}, {4{cac}}, 1'b1};
    return r;
  endfunction

  int               m_step = 0;
  logic [CNT_W-1:0] m_ret  = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_step <= 0;
      m_ret  <= '0;
    end else if (!(mem_step(cls_of(op), m_step) && !mem_ready)) begin
      if (m_step == last_step(cls_of(op))) begin
        m_step <= 0;
        m_ret  <= m_ret + 1;
      end else if (!(cls_of(op) == K_ILL && m_step == 2)) begin
        m_step <= m_step + 1;
      end
    end
  end

  exp_t        cmp_e;
  logic [19:0] cmp_d;
  always @(negedge clk) begin
    cmp_e = model_out(cls_of(op), m_step, mem_ready, reset);
    cmp_d = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};
    tests++;
    if ((cmp_d & cmp_e.m) !== (cmp_e.v & cmp_e.m)) begin
      fails++;
      $display("FAIL outputs t=%0t op=%b step=%0d got=%h required=%h care=%h",
               $time, op, m_step, cmp_d, cmp_e.v, cmp_e.m);
    end
    tests++;
    if (retired !== m_ret) begin
      fails++;
      $display("FAIL retired t=%0t got=%0d required=%0d", $time, retired, m_ret);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  logic       snap_regw[32], snap_pcw[32], snap_memw[32], snap_adr[32], snap_ill[32];
  logic [4:0] snap_strb[32];
  logic [3:0] snap_alu[32];
  logic [1:0] snap_res[32];
  logic [CNT_W-1:0] snap_ret[32];

  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic [3:0] znvc, input int ncyc, input logic [31:0] rdy);
    op = o; funct3 = f3; funct7b5 = f7; {Zero, n, v, C} = znvc;
    for (int i = 0; i < ncyc; i++) begin
      mem_ready = rdy[i];
      #2;
      snap_regw[i] = RegWrite;  snap_pcw[i] = PCWrite; snap_memw[i] = MemWrite;
      snap_adr[i]  = AdrSrc;    snap_ill[i] = illegal; snap_alu[i]  = ALUControl;
      snap_res[i]  = ResultSrc; snap_ret[i] = retired;
      snap_strb[i] = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite};
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [6:0] o; logic [2:0] f3; logic f7; logic [3:0] znvc; int nc; logic [31:0] rdy;
  } vec_t;

  vec_t tbl[14] = '{
    '{7'b0110011, 3'd0, 1'b1, 4'b0000, 4, 32'hF},   // sub
    '{7'b0010011, 3'd5, 1'b1, 4'b0000, 4, 32'hF},   // srai
    '{7'b0110011, 3'd7, 1'b0, 4'b0000, 4, 32'hF},   // and
    '{7'b0110011, 3'd2, 1'b0, 4'b0000, 4, 32'hF},   // slt
    '{7'b0010011, 3'd3, 1'b0, 4'b0000, 4, 32'hF},   // sltiu
    '{7'b1100011, 3'd0, 1'b0, 4'b1000, 3, 32'h7},   // beq taken
    '{7'b1100011, 3'd1, 1'b0, 4'b1000, 3, 32'h7},   // bne not taken
    '{7'b1100011, 3'd6, 1'b0, 4'b0000, 3, 32'h7},   // bltu taken
    '{7'b1100011, 3'd7, 1'b0, 4'b0000, 3, 32'h7},   // bgeu not taken
    '{7'b1100011, 3'd3, 1'b0, 4'b1111, 3, 32'h7},   // reserved funct3
    '{7'b1101111, 3'd0, 1'b0, 4'b0000, 4, 32'hF},   // jal
    '{7'b0110111, 3'd0, 1'b0, 4'b0000, 4, 32'hF},   // lui
    '{7'b0110011, 3'd1, 1'b0, 4'b0000, 6, 32'h3C},  // sll, fetch stalled 2 cycles
    '{7'b0000011, 3'd2, 1'b0, 4'b0000, 6, 32'h37}   // lw, one read wait state
  };

  logic [31:0] acc;
  logic [31:0] acc2;

  initial begin
    reset = 1'b0; op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
    Zero = 1'b0; n = 1'b0; v = 1'b0; C = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_pcwrite", {31'd0, PCWrite}, 32'd0);
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    check("reset_retired", retired, 32'd0);
    reset = 1'b1;

    run(7'b0000011, 3'd2, 1'b0, 4'b0000, 5, 32'h1F);
    acc = 0;
    for (int i = 0; i < 5; i++) acc[i] = snap_regw[i];
    check("lw_regwrite_cycle5_only", acc, 32'h10);
    check("lw_resultsrc_c5", {30'd0, snap_res[4]}, 32'd1);
    check("lw_retired", retired, 32'd1);

    run(7'b0100011, 3'd2, 1'b0, 4'b0000, 6, 32'h21);
    acc = 0; acc2 = 0;
    for (int i = 0; i < 6; i++) begin acc[i] = snap_memw[i]; acc2[i] = snap_adr[i]; end
    check("sw_memwrite_held", acc, 32'h38);
    check("sw_adrsrc_held", acc2 & 32'h38, 32'h38);
    check("sw_retired_during_wait", snap_ret[4], 32'd1);
    check("sw_retired", retired, 32'd2);

    run(7'b1100011, 3'd4, 1'b0, 4'b0100, 3, 32'h7);
    check("blt_taken_pcwrite", {31'd0, snap_pcw[2]}, 32'd1);
    run(7'b1100011, 3'd4, 1'b0, 4'b0110, 3, 32'h7);
    check("blt_not_taken_pcwrite", {31'd0, snap_pcw[2]}, 32'd0);
    check("branch_retired", retired, 32'd4);

    run(7'b0110011, 3'd5, 1'b1, 4'b0000, 4, 32'hF);
    check("sra_alucontrol", {28'd0, snap_alu[2]}, 32'hA);
    run(7'b0010011, 3'd0, 1'b1, 4'b0000, 4, 32'hF);
    check("addi_no_sub", {28'd0, snap_alu[2]}, 32'h0);

    for (int t = 0; t < 14; t++)
      run(tbl[t].o, tbl[t].f3, tbl[t].f7, tbl[t].znvc, tbl[t].nc, tbl[t].rdy);
    check("table_retired", retired, 32'd20);

    run(7'b1111111, 3'd0, 1'b0, 4'b0000, 22, 32'h3FFFFF);
    acc = 0; acc2 = 0;
    for (int i = 2; i < 22; i++) begin acc = acc | {27'd0, snap_strb[i]}; acc2 = acc2 + {31'd0, snap_ill[i]}; end
    check("trap_strobes_zero", acc, 32'd0);
    check("trap_illegal_count", acc2, 32'd20);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("trap_reset_illegal", {31'd0, illegal}, 32'd0);
    check("trap_reset_retired", retired, 32'd0);

    reset = 1'b1;
    run(7'b0000011, 3'd2, 1'b0, 4'b0000, 3, 32'h7);
    mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acc = acc | {30'd0, RegWrite, MemWrite};
    end
    check("abort_no_write", acc, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run(7'b0000011, 3'd2, 1'b0, 4'b0000, 3, 32'h4);
    acc = 0;
    for (int i = 0; i < 3; i++) acc[i] = snap_pcw[i];
    check("abort_fetch_pcwrite", acc, 32'h4);
    run(7'b0000011, 3'd2, 1'b0, 4'b0000, 4, 32'hF);
    check("abort_then_lw_retired", retired, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
